sdfm_data_arbiter: RTL and testbench

Collects filter results from NCH sigma-delta channels. Each channel supplies a 32-bit word and a one-cycle update strobe; the block holds one result per channel. A round-robin arbiter drains the held results into a single valid/ready output stream for the register/bus interface. The block also keeps sticky per-channel overrun flags and drives interrupt requests. It sits between the CHANNEL instances and the host-side register file.

---
 rtl/sdfm_pkg.sv | 17 +
 rtl/sdfm_rr_arbiter.sv | 42 ++++
 rtl/sdfm_data_arbiter.sv | 97 +++++++++
 tb/tb_sdfm_data_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sdfm_pkg.sv
// Shared definitions for the sigma-delta filter data path: default sizes,
// a constant-width helper and the output register state encoding.
package sdfm_pkg;

  localparam int SDFM_NCH = 4;
  localparam int SDFM_DW  = 32;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  typedef enum logic {EMPTY, FULL} out_state_t;

endpackage

// File: rtl/sdfm_rr_arbiter.sv
// Combinational round-robin picker: first asserted request strictly after
// last_grant, wrapping back through index 0 up to last_grant itself.
module sdfm_rr_arbiter
  import sdfm_pkg::*;
#(
  parameter int NCH = SDFM_NCH,
  parameter int CW  = 4
) (
  input  logic [NCH-1:0] req,
  input  logic [CW-1:0]  last_grant,
  output logic           gnt_valid,
  output logic [CW-1:0]  gnt_idx
);

  logic          hi_valid;
  logic          lo_valid;
  logic [CW-1:0] hi_idx;
  logic [CW-1:0] lo_idx;

  // Two priority passes avoid modulo arithmetic: the descending scan lets the
  // lowest index above last_grant win, else the lowest index at or below it.
  always_comb begin
    hi_valid = 1'b0;
    lo_valid = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (req[i]) begin
        if (CW'(i) > last_grant) begin
          hi_valid = 1'b1;
          hi_idx   = CW'(i);
        end else begin
          lo_valid = 1'b1;
          lo_idx   = CW'(i);
        end
      end
    end
    gnt_valid = hi_valid | lo_valid;
    gnt_idx   = hi_valid ? hi_idx : lo_idx;
  end

endmodule

// File: rtl/sdfm_data_arbiter.sv
// Holds one filter result per channel, drains them round-robin into a single
// valid/ready stream and tracks sticky per-channel overrun flags.
module sdfm_data_arbiter
  import sdfm_pkg::*;
#(
  parameter int NCH = SDFM_NCH,
  parameter int DW  = SDFM_DW,
  parameter int CW  = 4
) (
  input  logic              SYSCLK,
  input  logic              SYSRST,
  input  logic [NCH-1:0]    ch_en,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH-1:0]    ch_update,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [CW-1:0]     out_chan,
  output logic [NCH-1:0]    ovf_flag,
  input  logic [NCH-1:0]    ovf_clr,
  output logic              irq_data,
  output logic              irq_ovf
);

  out_state_t     state;
  out_state_t     state_next;
  logic [DW-1:0]  hold [NCH];
  logic [NCH-1:0] pend;
  logic [CW-1:0]  last_grant;
  logic           gnt_valid;
  logic [CW-1:0]  gnt_idx;
  logic           load;
  logic           grant;
  logic [NCH-1:0] granted;
  logic [NCH-1:0] ovf_set;
  logic [DW-1:0]  sel_data;

  sdfm_rr_arbiter #(.NCH(NCH), .CW(CW)) u_arb (
    .req        (pend),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  // A granted channel that updates in the same cycle is not an overrun.
  always_comb begin
    load     = (state == EMPTY) || out_ready;
    grant    = load && gnt_valid;
    sel_data = '0;
    for (int i = 0; i < NCH; i++) begin
      granted[i] = grant && (gnt_idx == CW'(i));
      if (gnt_idx == CW'(i)) sel_data = hold[i];
    end
    ovf_set = ch_update & ch_en & pend & ~granted;
  end

  always_comb begin
    state_next = state;
    if (load) state_next = gnt_valid ? FULL : EMPTY;
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) state <= EMPTY;
    else        state <= state_next;
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      pend       <= '0;
      ovf_flag   <= '0;
      last_grant <= CW'(NCH - 1);
      out_data   <= '0;
      out_chan   <= '0;
      for (int i = 0; i < NCH; i++) hold[i] <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_update[i] && ch_en[i]) begin
          hold[i] <= ch_data[i*DW +: DW];
          pend[i] <= 1'b1;
        end else if (!ch_en[i] || granted[i]) begin
          pend[i] <= 1'b0;
        end
      end
      ovf_flag <= (ovf_flag & ~ovf_clr) | ovf_set;
      if (grant) begin
        out_data   <= sel_data;
        out_chan   <= gnt_idx;
        last_grant <= gnt_idx;
      end
    end
  end

  assign out_valid = (state == FULL);
  assign irq_data  = out_valid;
  assign irq_ovf   = |ovf_flag;

endmodule

// File: tb/tb_sdfm_data_arbiter.sv
// Randomized and directed bench for sdfm_data_arbiter with a cycle-level
// behavioural model feeding an output-word scoreboard.
module tb_sdfm_data_arbiter;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int CW  = 4;

  typedef struct {
    logic [CW-1:0] chan;
    logic [DW-1:0] data;
  } word_t;

  logic              SYSCLK;
  logic              SYSRST;
  logic [NCH-1:0]    ch_en;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_update;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_data;
  logic [CW-1:0]     out_chan;
  logic [NCH-1:0]    ovf_flag;
  logic [NCH-1:0]    ovf_clr;
  logic              irq_data;
  logic              irq_ovf;

  int errors;
  int checks;

  // Model state as seen just after the upcoming clock edge.
  logic [DW-1:0]  m_held [NCH];
  logic [NCH-1:0] m_pend;
  logic [NCH-1:0] m_ovf;
  int             m_lg;
  logic           m_full;
  word_t          exp_q [$];

  sdfm_data_arbiter #(.NCH(NCH), .DW(DW), .CW(CW)) dut (
    .SYSCLK    (SYSCLK),
    .SYSRST    (SYSRST),
    .ch_en     (ch_en),
    .ch_data   (ch_data),
    .ch_update (ch_update),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_chan  (out_chan),
    .ovf_flag  (ovf_flag),
    .ovf_clr   (ovf_clr),
    .irq_data  (irq_data),
    .irq_ovf   (irq_ovf)
  );

  initial SYSCLK = 1'b0;
  always #5 SYSCLK = ~SYSCLK;

  task automatic checkValue(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    checkValue("out_valid", DW'(out_valid), DW'(m_full));
    checkValue("irq_data", DW'(irq_data), DW'(m_full));
    checkValue("ovf_flag", DW'(ovf_flag), DW'(m_ovf));
    checkValue("irq_ovf", DW'(irq_ovf), DW'(m_ovf != '0));
  endtask

  // Predicts the effect of the next clock edge given the inputs just driven.
  task automatic modelStep();
    int g;
    logic [NCH-1:0] set_mask;
    g = -1;
    if (SYSRST) begin
      for (int i = 0; i < NCH; i++) m_held[i] = '0;
      m_pend = '0;
      m_ovf  = '0;
      m_lg   = NCH - 1;
      m_full = 1'b0;
      exp_q.delete();
      return;
    end
    if (!m_full || out_ready) begin
      for (int k = 1; k <= NCH; k++) begin
        int c;
        c = (m_lg + k) % NCH;
        if (m_pend[c]) begin
          g = c;
          break;
        end
      end
      if (g >= 0) begin
        word_t w;
        w.chan = CW'(g);
        w.data = m_held[g];
        exp_q.push_back(w);
        m_lg   = g;
        m_full = 1'b1;
      end else begin
        m_full = 1'b0;
      end
    end
    set_mask = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch_update[i] && ch_en[i]) begin
        if (m_pend[i] && i != g) set_mask[i] = 1'b1;
        m_held[i] = ch_data[i*DW +: DW];
        m_pend[i] = 1'b1;
      end else if (!ch_en[i] || i == g) begin
        m_pend[i] = 1'b0;
      end
    end
    m_ovf = (m_ovf & ~ovf_clr) | set_mask;
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] en, input logic [NCH-1:0] upd,
                               input logic [NCH*DW-1:0] data, input logic rdy,
                               input logic [NCH-1:0] clr, input logic rst);
    @(posedge SYSCLK);
    #1;
    checkOutput();
    ch_en     = en;
    ch_update = upd;
    ch_data   = data;
    out_ready = rdy;
    ovf_clr   = clr;
    SYSRST    = rst;
    modelStep();
  endtask

  function automatic logic [NCH*DW-1:0] pack4(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                              input logic [DW-1:0] d2, input logic [DW-1:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  // Scoreboard: every accepted word must match the oldest predicted grant.
  initial begin
    forever begin
      @(negedge SYSCLK);
      if (!SYSRST && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_word: got chan %0d data 0x%0h, expected none", out_chan, out_data);
        end else begin
          word_t w;
          w = exp_q.pop_front();
          checkValue("out_chan", DW'(out_chan), DW'(w.chan));
          checkValue("out_data", out_data, w.data);
        end
      end
    end
  end

  initial begin
    logic [NCH*DW-1:0] z;
    errors = 0;
    checks = 0;
    z = '0;
    ch_en = '1; ch_update = '0; ch_data = '0; out_ready = 1'b0; ovf_clr = '0;
    SYSRST = 1'b1;
    modelStep();
    applyStimulus('1, '0, z, 1'b1, '0, 1'b1);
    applyStimulus('1, '0, z, 1'b1, '0, 1'b0);

    // Single update on channel 2
    applyStimulus('1, 4'b0100, pack4(0, 0, 32'h0000_1234, 0), 1'b1, '0, 1'b0);
    repeat (3) applyStimulus('1, '0, z, 1'b1, '0, 1'b0);

    // All channels at once, consumer stalled for three cycles
    applyStimulus('1, 4'b1111, pack4(32'hA0, 32'hA1, 32'hA2, 32'hA3), 1'b0, '0, 1'b0);
    repeat (3) applyStimulus('1, '0, z, 1'b0, '0, 1'b0);
    repeat (6) applyStimulus('1, '0, z, 1'b1, '0, 1'b0);

    // Fairness between channels 0 and 3 after a grant to channel 1
    applyStimulus('1, 4'b0010, pack4(0, 32'h1, 0, 0), 1'b1, '0, 1'b0);
    repeat (3) applyStimulus('1, '0, z, 1'b1, '0, 1'b0);
    for (int i = 0; i < 8; i++)
      applyStimulus('1, 4'b1001, pack4($urandom, 0, 0, $urandom), 1'b1, '0, 1'b0);
    repeat (4) applyStimulus('1, '0, z, 1'b1, '0, 1'b0);

    // Overrun on channel 1 while stalled, then set-versus-clear
    applyStimulus('1, 4'b0001, pack4(32'h01, 0, 0, 0), 1'b0, '0, 1'b0);
    applyStimulus('1, 4'b0010, pack4(0, 32'h11, 0, 0), 1'b0, '0, 1'b0);
    applyStimulus('1, 4'b0010, pack4(0, 32'h55, 0, 0), 1'b0, '0, 1'b0);
    applyStimulus('1, '0, z, 1'b0, '0, 1'b0);
    applyStimulus('1, 4'b0010, pack4(0, 32'h66, 0, 0), 1'b0, 4'b0010, 1'b0);
    applyStimulus('1, '0, z, 1'b0, '0, 1'b0);
    applyStimulus('1, '0, z, 1'b0, 4'b0010, 1'b0);
    repeat (5) applyStimulus('1, '0, z, 1'b1, '0, 1'b0);

    // Same-cycle grant and update on channel 0
    applyStimulus('1, 4'b0001, pack4(32'h10, 0, 0, 0), 1'b1, '0, 1'b0);
    applyStimulus('1, 4'b0001, pack4(32'h20, 0, 0, 0), 1'b1, '0, 1'b0);
    repeat (4) applyStimulus('1, '0, z, 1'b1, '0, 1'b0);

    // Disabled channel ignores its strobe; reset while full
    applyStimulus(4'b0111, 4'b1000, pack4(0, 0, 0, 32'hDEAD), 1'b1, '0, 1'b0);
    repeat (3) applyStimulus(4'b0111, '0, z, 1'b1, '0, 1'b0);
    applyStimulus('1, 4'b1111, pack4(32'hB0, 32'hB1, 32'hB2, 32'hB3), 1'b0, '0, 1'b0);
    applyStimulus('1, 4'b0100, pack4(0, 0, 32'hC2, 0), 1'b0, '0, 1'b0);
    applyStimulus('1, '0, z, 1'b1, '0, 1'b1);
    applyStimulus('1, 4'b1111, pack4(32'hD0, 32'hD1, 32'hD2, 32'hD3), 1'b1, '0, 1'b0);
    repeat (6) applyStimulus('1, '0, z, 1'b1, '0, 1'b0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [NCH-1:0] en;
      logic [NCH-1:0] clr;
      logic [NCH*DW-1:0] d;
      for (int i = 0; i < NCH; i++) d[i*DW +: DW] = $urandom;
      en  = ($urandom_range(0, 9) == 0) ? NCH'($urandom) : '1;
      clr = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      applyStimulus(en, NCH'($urandom), d, $urandom_range(0, 3) != 0, clr,
                    $urandom_range(0, 199) == 0);
    end

    repeat (10) applyStimulus('1, '0, z, 1'b1, '0, 1'b0);
    @(negedge SYSCLK);
    checkValue("drained", DW'(exp_q.size()), DW'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
